// File: rtl/simd_wb_queue_if.sv
// SIMD ALU to VGPR writeback bus: ALU push side, RFA grant, VGPR write port and retire outputs.
// master = ALU/RFA side driving requests; slave = the writeback queue.
interface simd_wb_queue_if;
  logic          alu_vgpr_wr_en;
  logic [9:0]    alu_vgpr_dest_addr;
  logic [2047:0] alu_vgpr_dest_data;
  logic [63:0]   alu_vgpr_wr_mask;
  logic          alu_instr_done;
  logic [5:0]    alu_instr_done_wfid;
  logic [31:0]   alu_retire_pc;
  logic          rfa_queue_entry_serviced;
  logic          alu_wb_stall;
  logic          rfa_queue_entry_valid;
  logic          vgpr_wr_en;
  logic [9:0]    vgpr_dest_addr;
  logic [2047:0] vgpr_dest_data;
  logic [63:0]   vgpr_wr_mask;
  logic          vgpr_instr_done;
  logic [5:0]    vgpr_instr_done_wfid;
  logic [31:0]   tracemon_retire_pc;
  logic          wb_overflow;

  modport master (
    output alu_vgpr_wr_en, alu_vgpr_dest_addr, alu_vgpr_dest_data, alu_vgpr_wr_mask,
           alu_instr_done, alu_instr_done_wfid, alu_retire_pc, rfa_queue_entry_serviced,
    input  alu_wb_stall, rfa_queue_entry_valid, vgpr_wr_en, vgpr_dest_addr, vgpr_dest_data,
           vgpr_wr_mask, vgpr_instr_done, vgpr_instr_done_wfid, tracemon_retire_pc, wb_overflow
  );

  modport slave (
    input  alu_vgpr_wr_en, alu_vgpr_dest_addr, alu_vgpr_dest_data, alu_vgpr_wr_mask,
           alu_instr_done, alu_instr_done_wfid, alu_retire_pc, rfa_queue_entry_serviced,
    output alu_wb_stall, rfa_queue_entry_valid, vgpr_wr_en, vgpr_dest_addr, vgpr_dest_data,
           vgpr_wr_mask, vgpr_instr_done, vgpr_instr_done_wfid, tracemon_retire_pc, wb_overflow
  );
endinterface

// File: rtl/simd_wb_queue.sv
// In-order writeback queue between the SIMD ALU and the VGPR write port.
// Entries leave one cycle after the RFA grant; a push into a full queue without a pop is dropped and flagged.
module simd_wb_queue #(
  parameter int PTR_W = 2
) (
  input logic           clk,
  input logic           rst,
  simd_wb_queue_if.slave bus
);
  localparam int DEPTH = 1 << PTR_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic          wr_en;
    logic [9:0]    addr;
    logic [2047:0] data;
    logic [63:0]   mask;
    logic          done;
    logic [5:0]    wfid;
    logic [31:0]   pc;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push_req, push, pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = bus.alu_vgpr_wr_en | bus.alu_instr_done;
  assign pop      = bus.rfa_queue_entry_serviced & ~empty;
  assign push     = push_req & (~full | pop);
  assign head     = mem[rd_ptr];

  assign bus.alu_wb_stall          = full;
  assign bus.rfa_queue_entry_valid = ~empty;

  // Storage is left uninitialised; count and pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{wr_en: bus.alu_vgpr_wr_en, addr: bus.alu_vgpr_dest_addr,
                       data: bus.alu_vgpr_dest_data, mask: bus.alu_vgpr_wr_mask,
                       done: bus.alu_instr_done, wfid: bus.alu_instr_done_wfid,
                       pc: bus.alu_retire_pc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.wb_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) bus.wb_overflow <= 1'b1;
    end
  end

  // Strobes pulse only after a pop; payload fields hold their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vgpr_wr_en           <= 1'b0;
      bus.vgpr_instr_done      <= 1'b0;
      bus.vgpr_dest_addr       <= '0;
      bus.vgpr_dest_data       <= '0;
      bus.vgpr_wr_mask         <= '0;
      bus.vgpr_instr_done_wfid <= '0;
      bus.tracemon_retire_pc   <= '0;
    end else begin
      bus.vgpr_wr_en      <= pop & head.wr_en;
      bus.vgpr_instr_done <= pop & head.done;
      if (pop) begin
        bus.vgpr_dest_addr       <= head.addr;
        bus.vgpr_dest_data       <= head.data;
        bus.vgpr_wr_mask         <= head.mask;
        bus.vgpr_instr_done_wfid <= head.wfid;
        bus.tracemon_retire_pc   <= head.pc;
      end
    end
  end
endmodule

// File: tb/tb_simd_wb_queue.sv
// Directed bench for simd_wb_queue: a vector table for single-step behaviour plus
// hand-written sequences for full push/pop, pointer wrap and mid-drain reset.
module tb_simd_wb_queue;
  logic clk, rst;
  int   total = 0;
  int   bad   = 0;

  simd_wb_queue_if bus ();
  simd_wb_queue #(.PTR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr, done, srv;
    logic [9:0]  addr;
    logic [63:0] mask;
    logic [5:0]  wfid;
    logic        e_stall, e_valid, e_vwr, e_vdone, e_ovf;
    logic [9:0]  e_addr;
    logic [63:0] e_mask;
    logic [5:0]  e_wfid;
  } vec_t;

  vec_t vecs [16];
  logic [9:0] exp_q [$];

  function automatic logic [2047:0] mk_data(input logic [9:0] a);
    logic [31:0] w;
    w = {a, 22'(a) * 22'd3};
    return {64{w}};
  endfunction

  function automatic logic [31:0] mk_pc(input logic [9:0] a);
    return {a, 12'h0, a};
  endfunction

  function automatic logic [63:0] mk_mask(input logic [9:0] a);
    return {a, 44'h5A5_A5A5_A5A5, a};
  endfunction

  function automatic vec_t mk(input logic wr, done, srv, input logic [9:0] addr,
                              input logic [63:0] mask, input logic [5:0] wfid,
                              input logic st, va, vw, vd, ov, input logic [9:0] ea,
                              input logic [63:0] em, input logic [5:0] ew);
    vec_t v;
    v.wr = wr; v.done = done; v.srv = srv; v.addr = addr; v.mask = mask; v.wfid = wfid;
    v.e_stall = st; v.e_valid = va; v.e_vwr = vw; v.e_vdone = vd; v.e_ovf = ov;
    v.e_addr = ea; v.e_mask = em; v.e_wfid = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low64 %h expected low64 %h", nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic drive(input logic wr, done, srv, input logic [9:0] addr,
                       input logic [63:0] mask, input logic [5:0] wfid);
    bus.alu_vgpr_wr_en           = wr;
    bus.alu_instr_done           = done;
    bus.rfa_queue_entry_serviced = srv;
    bus.alu_vgpr_dest_addr       = addr;
    bus.alu_vgpr_dest_data       = mk_data(addr);
    bus.alu_vgpr_wr_mask         = mask;
    bus.alu_instr_done_wfid      = wfid;
    bus.alu_retire_pc            = mk_pc(addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Applied at posedge+1; pulses rst between edges.
  task automatic pulse_reset();
    drive(0, 0, 0, 10'h0, 64'h0, 6'h0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " vgpr_wr_en"}, 64'(bus.vgpr_wr_en), 64'h0);
    chk({tag, " vgpr_instr_done"}, 64'(bus.vgpr_instr_done), 64'h0);
    chk({tag, " stall"}, 64'(bus.alu_wb_stall), 64'h0);
    chk({tag, " valid"}, 64'(bus.rfa_queue_entry_valid), 64'h0);
    chk({tag, " overflow"}, 64'(bus.wb_overflow), 64'h0);
    chk({tag, " addr"}, 64'(bus.vgpr_dest_addr), 64'h0);
    chk({tag, " mask"}, bus.vgpr_wr_mask, 64'h0);
    chk({tag, " wfid"}, 64'(bus.vgpr_instr_done_wfid), 64'h0);
    chk({tag, " pc"}, 64'(bus.tracemon_retire_pc), 64'h0);
    chk_wide({tag, " data"}, bus.vgpr_dest_data, '0);
  endtask

  initial begin
    int got;
    int occ;
    logic exp_pop;
    rst = 1'b1;
    drive(0, 0, 0, 10'h0, 64'h0, 6'h0);
    #3;
    chk_outputs_zero("reset");
    step();
    rst = 1'b0;

    vecs[0]  = mk(1, 1, 0, 10'h5, '1, 6'd3,  0, 1, 0, 0, 0, 10'h0, 64'h0, 6'd0);
    vecs[1]  = mk(0, 0, 1, 10'h0, 64'h0, 6'd0, 0, 0, 1, 1, 0, 10'h5, '1, 6'd3);
    vecs[2]  = mk(0, 0, 0, 10'h0, 64'h0, 6'd0, 0, 0, 0, 0, 0, 10'h5, '1, 6'd3);
    vecs[3]  = mk(0, 0, 1, 10'h0, 64'h0, 6'd0, 0, 0, 0, 0, 0, 10'h5, '1, 6'd3);
    vecs[4]  = mk(0, 1, 1, 10'h7, 64'h0, 6'd9, 0, 1, 0, 0, 0, 10'h5, '1, 6'd3);
    vecs[5]  = mk(0, 0, 1, 10'h0, 64'h0, 6'd0, 0, 0, 0, 1, 0, 10'h7, 64'h0, 6'd9);
    for (int a = 0; a < 4; a++)
      vecs[6+a] = mk(1, 0, 0, 10'(a), mk_mask(10'(a)), 6'(a),
                     (a == 3), 1, 0, 0, 0, 10'h7, 64'h0, 6'd9);
    vecs[10] = mk(1, 0, 0, 10'h4, mk_mask(10'h4), 6'd4, 1, 1, 0, 0, 1, 10'h7, 64'h0, 6'd9);
    for (int a = 0; a < 4; a++)
      vecs[11+a] = mk(0, 0, 1, 10'h0, 64'h0, 6'd0, 0, (a != 3), 1, 0, 1,
                      10'(a), mk_mask(10'(a)), 6'(a));
    vecs[15] = mk(0, 0, 1, 10'h0, 64'h0, 6'd0, 0, 0, 0, 0, 1, 10'h3, mk_mask(10'h3), 6'd3);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wr, vecs[i].done, vecs[i].srv, vecs[i].addr, vecs[i].mask, vecs[i].wfid);
      step();
      chk($sformatf("v%0d stall", i), 64'(bus.alu_wb_stall), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d valid", i), 64'(bus.rfa_queue_entry_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d vgpr_wr_en", i), 64'(bus.vgpr_wr_en), 64'(vecs[i].e_vwr));
      chk($sformatf("v%0d instr_done", i), 64'(bus.vgpr_instr_done), 64'(vecs[i].e_vdone));
      chk($sformatf("v%0d overflow", i), 64'(bus.wb_overflow), 64'(vecs[i].e_ovf));
      chk($sformatf("v%0d addr", i), 64'(bus.vgpr_dest_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d mask", i), bus.vgpr_wr_mask, vecs[i].e_mask);
      chk($sformatf("v%0d wfid", i), 64'(bus.vgpr_instr_done_wfid), 64'(vecs[i].e_wfid));
      chk($sformatf("v%0d pc", i), 64'(bus.tracemon_retire_pc), 64'(mk_pc(vecs[i].e_addr)));
      chk_wide($sformatf("v%0d data", i), bus.vgpr_dest_data, mk_data(vecs[i].e_addr));
    end

    // Full queue with simultaneous push and pop: no overflow, new entry lands last.
    pulse_reset();
    chk("fullpp overflow cleared", 64'(bus.wb_overflow), 64'h0);
    for (int a = 10; a < 14; a++) begin
      drive(1, 0, 0, 10'(a), mk_mask(10'(a)), 6'(a));
      step();
    end
    chk("fullpp stall", 64'(bus.alu_wb_stall), 64'h1);
    drive(1, 0, 1, 10'd14, mk_mask(10'd14), 6'd14);
    step();
    chk("fullpp stall held", 64'(bus.alu_wb_stall), 64'h1);
    chk("fullpp overflow", 64'(bus.wb_overflow), 64'h0);
    chk("fullpp vgpr_wr_en", 64'(bus.vgpr_wr_en), 64'h1);
    chk("fullpp addr", 64'(bus.vgpr_dest_addr), 64'd10);
    for (int a = 11; a < 15; a++) begin
      drive(0, 0, 1, 10'h0, 64'h0, 6'h0);
      step();
      chk($sformatf("fullpp drain%0d addr", a), 64'(bus.vgpr_dest_addr), 64'(a));
      chk($sformatf("fullpp drain%0d wr_en", a), 64'(bus.vgpr_wr_en), 64'h1);
    end
    chk("fullpp empty", 64'(bus.rfa_queue_entry_valid), 64'h0);

    // Pointer wrap: 10 pushes interleaved with pops, checked against a scoreboard.
    got = 0;
    occ = 0;
    for (int i = 0; i < 30 && got < 10; i++) begin
      logic srv, pu;
      srv = (i >= 2);
      pu  = (i < 10);
      drive(pu, 0, srv, 10'(40 + i), mk_mask(10'(40 + i)), 6'(i));
      exp_pop = srv && (occ > 0);
      step();
      chk($sformatf("wrap c%0d wr_en", i), 64'(bus.vgpr_wr_en), 64'(exp_pop));
      if (exp_pop && exp_q.size() > 0) begin
        chk($sformatf("wrap c%0d addr", i), 64'(bus.vgpr_dest_addr), 64'(exp_q.pop_front()));
        got++;
        occ--;
      end
      if (pu) begin
        exp_q.push_back(10'(40 + i));
        occ++;
      end
      if (occ > 3) chk("wrap occupancy bound", 64'(occ), 64'd3);
    end
    chk("wrap pulses", 64'(got), 64'd10);

    // Reset between edges while two entries remain queued.
    pulse_reset();
    for (int a = 50; a < 53; a++) begin
      drive(1, 1, 0, 10'(a), mk_mask(10'(a)), 6'(a));
      step();
    end
    drive(0, 0, 1, 10'h0, 64'h0, 6'h0);
    step();
    chk("rstmid pre addr", 64'(bus.vgpr_dest_addr), 64'd50);
    chk("rstmid pre valid", 64'(bus.rfa_queue_entry_valid), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("rstmid");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rstmid post%0d valid", i), 64'(bus.rfa_queue_entry_valid), 64'h0);
      chk($sformatf("rstmid post%0d wr_en", i), 64'(bus.vgpr_wr_en), 64'h0);
      chk($sformatf("rstmid post%0d done", i), 64'(bus.vgpr_instr_done), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simd_wb_queue.md
SIMD_WB_QUEUE -- requirements
Module: simd_wb_queue

Interface
REQ-001 SHALL have parameter PTR_W, default 2, meaning log2 of queue depth; depth DEPTH = 2**PTR_W (default 4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port alu_vgpr_wr_en, input, 1, the SIMD ALU requests a VGPR write this cycle.
REQ-005 SHALL have port alu_vgpr_dest_addr, input, 10, VGPR destination address.
REQ-006 SHALL have port alu_vgpr_dest_data, input, 2048, 64 lanes x 32-bit result.
REQ-007 SHALL have port alu_vgpr_wr_mask, input, 64, per-lane write mask.
REQ-008 SHALL have port alu_instr_done, input, 1, the instruction retires with this entry.
REQ-009 SHALL have port alu_instr_done_wfid, input, 6, wavefront id of the retiring instruction.
REQ-010 SHALL have port alu_retire_pc, input, 32, PC of the retiring instruction.
REQ-011 SHALL have port rfa_queue_entry_serviced, input, 1, the RFA grants the VGPR write port to the head entry.
REQ-012 SHALL have port alu_wb_stall, output, 1, queue full; the ALU holds its result.
REQ-013 SHALL have port rfa_queue_entry_valid, output, 1, the queue holds at least one entry.
REQ-014 SHALL have ports vgpr_wr_en (1), vgpr_dest_addr (10), vgpr_dest_data (2048) and vgpr_wr_mask (64), all outputs, the VGPR write port.
REQ-015 SHALL have ports vgpr_instr_done (1), vgpr_instr_done_wfid (6) and tracemon_retire_pc (32), all outputs, retirement to the issue stage and the trace monitor.
REQ-016 SHALL have port wb_overflow, output, 1, sticky error flag for a push into a full queue.

Function
REQ-017 SHALL push an entry {wr_en, addr, data, mask, done, wfid, pc} when (alu_vgpr_wr_en OR alu_instr_done) is high, so done-only entries keep retirement in order.
REQ-018 SHALL accept a push when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-019 SHALL drop a push that arrives while full with no same-cycle pop, leave count unchanged and set wb_overflow until reset.
REQ-020 SHALL drive alu_wb_stall = (count == DEPTH) and rfa_queue_entry_valid = (count != 0), both decoded combinationally from registered count only.
REQ-021 SHALL pop the head entry when rfa_queue_entry_serviced AND count != 0.
REQ-022 SHALL ignore rfa_queue_entry_serviced while empty: no pop, no output pulse.
REQ-023 SHALL register each popped entry onto the vgpr_* and retire outputs on the edge after the pop cycle (latency 1).
REQ-024 SHALL pulse vgpr_wr_en and vgpr_instr_done for exactly one cycle per pop, each equal to the entry's stored flag.
REQ-025 SHALL hold vgpr_wr_en and vgpr_instr_done low in every cycle that does not follow a pop.
REQ-026 SHALL hold the data, address, mask, wfid and pc outputs at their last value between pops.
REQ-027 SHALL count as a PTR_W+1-bit counter; on a simultaneous push and pop, count is unchanged.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL retire entries in strict FIFO order, with no reordering across wavefronts.
REQ-030 SHALL allow a push into an empty queue to be popped no earlier than the following cycle (no bypass).

Reset
REQ-031 SHALL, on rst assertion and regardless of clk, clear count, both pointers and wb_overflow.
REQ-032 SHALL, on rst assertion and regardless of clk, force vgpr_wr_en, vgpr_instr_done, alu_wb_stall and rfa_queue_entry_valid low.
REQ-033 SHALL, on rst assertion and regardless of clk, zero vgpr_dest_addr, vgpr_dest_data, vgpr_wr_mask, vgpr_instr_done_wfid and tracemon_retire_pc.
REQ-034 SHALL discard all in-flight entries on reset mid-operation; queue storage need not be cleared.

Verification
REQ-035 Single push: addr=0x005, mask=all-ones, done=1, wfid=3, then serviced one cycle later -> valid high one cycle after push; one-cycle vgpr_wr_en and vgpr_instr_done pulse with addr 0x005 and wfid 3 on the edge after the serviced cycle.
REQ-036 Fill: 4 pushes with no service -> alu_wb_stall=1 after the 4th; a 5th push sets wb_overflow=1 and count stays 4; draining 4 pops returns addr order 0,1,2,3.
REQ-037 Full with simultaneous push and pop -> count stays 4, stall stays 1, wb_overflow stays 0; the new entry pops after the remaining 3.
REQ-038 Wrap-around: 10 pushes interleaved with pops, occupancy never exceeding 3 -> output order identical to input order across pointer wrap.
REQ-039 Serviced pulses while empty, and a done-only entry (wr_en=0, done=1) -> no output pulse while empty; the done-only entry gives vgpr_instr_done=1 and vgpr_wr_en=0.
REQ-040 Reset asserted mid-drain with 2 entries queued, between clock edges -> all outputs low or zero immediately; valid=0 after release; no stale entry popped.
